// File: rtl/seq_sort_engine.sv
// seq_sort_engine
//   Sequential sorter for N unsigned W-bit elements using odd-even
//   transposition: one compare/swap phase per clock, N phases per sort.
//   Sorting is stable (equal elements never swap). Swap count is reported
//   alongside the result and equals the inversion count of the input.
//
// Ports
//   clk        rising-edge clock
//   nrst       asynchronous active-low reset
//   start      load din/desc and begin a sort (accepted only when idle)
//   desc       0 = ascending, 1 = descending; sampled with start
//   din        N packed elements, element k = din[k*W +: W]
//   in_ready   engine idle, start will be accepted
//   out_valid  dout/swap_cnt hold a finished result
//   out_ready  consumer accepts the result (sampled only while holding)
//   dout       sorted elements, same packing as din
//   swap_cnt   number of swaps performed for this result
module seq_sort_engine #(
  parameter int N = 4,
  parameter int W = 4,
  localparam int CW = $clog2(N*(N-1)/2+1)
) (
  input  logic           clk,
  input  logic           nrst,
  input  logic           start,
  input  logic           desc,
  input  logic [N*W-1:0] din,
  output logic           in_ready,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N*W-1:0] dout,
  output logic [CW-1:0]  swap_cnt
);

  localparam int PW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SORT = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t               state_q;
  logic [N-1:0][W-1:0]  buf_q;
  logic [N-1:0][W-1:0]  buf_nxt;
  logic [PW-1:0]        phase_q;
  logic                 mode_q;
  logic [CW-1:0]        cnt_q;
  logic [CW-1:0]        nswap;

  // One transposition phase. Pairs start at even indices on even phases and
  // at odd indices on odd phases; pairs of the same parity never overlap, so
  // all comparisons in a phase read the registered buffer independently.
  always_comb begin
    buf_nxt = buf_q;
    nswap   = '0;
    for (int unsigned k = 0; k + 1 < N; k++) begin
      if (k[0] == phase_q[0]) begin
        if (mode_q ? (buf_q[k] < buf_q[k+1]) : (buf_q[k] > buf_q[k+1])) begin
          buf_nxt[k]   = buf_q[k+1];
          buf_nxt[k+1] = buf_q[k];
          nswap        = nswap + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      buf_q   <= '0;
      phase_q <= '0;
      mode_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            buf_q   <= din;
            mode_q  <= desc;
            phase_q <= '0;
            cnt_q   <= '0;
            state_q <= SORT;
          end
        end
        SORT: begin
          buf_q   <= buf_nxt;
          cnt_q   <= cnt_q + nswap;
          phase_q <= phase_q + PW'(1);
          if (phase_q == PW'(N-1))
            state_q <= HOLD;
        end
        HOLD: begin
          if (out_ready)
            state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == HOLD);
  assign dout      = buf_q;
  assign swap_cnt  = cnt_q;

endmodule

// File: doc/seq_sort_engine.md
Name: seq_sort_engine

Overview:
Parametrised, clocked successor to the team's combinational nibble sorter. Sorts N unsigned W-bit elements using odd-even transposition, one compare/swap phase per clock. This keeps the compare network at N/2 comparators instead of an unrolled bubble network. Sits behind a valid/ready style handshake, supports runtime ascending/descending mode, and reports the swap count.

Parameters:
N, 4, number of elements (N >= 2, odd or even)
W, 4, element width in bits, unsigned
CW, $clog2(N*(N-1)/2+1), swap-count width (derived, not overridden)

Ports:
clk  input  1  single clock, rising edge
nrst  input  1  asynchronous active-low reset
start  input  1  request to load and sort din
desc  input  1  0 = ascending, 1 = descending; sampled with start
din  input  N*W  element k = din[k*W +: W], element 0 at LSBs
in_ready  output  1  engine idle, start will be accepted
out_valid  output  1  dout/swap_cnt hold a finished result
out_ready  input  1  consumer accepts result
dout  output  N*W  sorted elements, same packing as din
swap_cnt  output  CW  number of swaps performed for this result

Behaviour:
- Reset (nrst low, async):
  - state IDLE; in_ready=1; out_valid=0; dout=0; swap_cnt=0.
  - Internal buffer, phase counter and mode register are cleared.
  - Reset asserted mid-sort or mid-hold aborts the operation. No partial result is ever presented.
- States: IDLE, SORT, HOLD.
- IDLE:
  - in_ready=1.
  - On an edge with start=1: latch din into the buffer and desc into the mode register, clear phase to 0 and swap_cnt to 0, then go to SORT.
  - start=0: remain in IDLE.
- SORT:
  - in_ready=0, out_valid=0. start is ignored; din and desc changes have no effect.
  - Each edge executes phase p on the buffer, then increments p.
    - Even p: compare pairs (0,1),(2,3),...
    - Odd p: compare pairs (1,2),(3,4),...
    - An unpaired last element (odd N on even phases, even N on odd phases) passes through unchanged.
  - Ascending: swap pair (k,k+1) iff elem[k] > elem[k+1]. Descending: swap iff elem[k] < elem[k+1]. Equal elements are never swapped (stable).
  - swap_cnt increments by the number of swaps in the phase. It saturates only by construction: the maximum is N(N-1)/2, which equals the inversion count.
  - After the edge executing phase N-1: go to HOLD.
- HOLD:
  - out_valid=1; dout = buffer; swap_cnt is stable. Both hold until handshake.
  - On an edge with out_valid & out_ready: go to IDLE. in_ready=1 from the next cycle; out_valid=0 and dout/swap_cnt are retained.
  - start is ignored in HOLD. There is no overlap of load and unload.
- Latency: acceptance edge E0; out_valid high after edge E0+N. Fixed and data-independent: no early exit.
- Throughput: one sort per N+2 cycles minimum (accept, N phases, unload).
- out_ready is only sampled in HOLD.
- Arithmetic: unsigned compare on full W bits. Phase counter width is $clog2(N).

Test Plan:
- N=4, W=4, desc=0, din=16'h1234 (e0=4,e1=3,e2=2,e3=1) -> out_valid rises 4 cycles after accept; dout=16'h4321; swap_cnt=6.
- Same din with desc=1 -> dout=16'h1234; swap_cnt=0. Then din=16'hA5A5, desc=0 -> dout=16'hAA55; swap_cnt=1 (equal values unswapped).
- Hold result with out_ready=0 for 10 cycles while toggling start/din -> dout, swap_cnt and out_valid stable; in_ready=0; next result unaffected.
- Assert nrst low 2 cycles after accept (mid-SORT) -> out_valid=0, in_ready=1, dout=0 immediately. A fresh start sorts correctly with no residue.
- N=5, W=8, desc=0, din elements {e0..e4}={8'hFF,8'h00,8'h80,8'h7F,8'h01} -> dout elements {00,01,7F,80,FF}; swap_cnt=7; latency 5.
- Randomised N=8, W=4, 500 vectors, random desc/out_ready stalls, vs. software model -> dout matches; swap_cnt = inversion count.
